// File: rtl/led_pattern_gen.sv
// LED bank pattern generator: off, blink-all, bouncing scanner or breathing PWM,
// stepped by a power-of-two prescaler whose rate is selected at run time.
module led_pattern_gen #(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned PRESC_W  = 20,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [3:0]        speed_i,
    output logic [N_LEDS-1:0] led_o,
    output logic              step_o
);

    localparam int unsigned POS_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int unsigned SHIFT_W = (PRESC_W > 1) ? $clog2(PRESC_W) : 1;

    localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]    POS_PENULT = POS_W'(N_LEDS - 2);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_SCAN    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    mode_e               mode_q, mode_d;
    logic [PRESC_W-1:0]  pre_q, pre_d;
    logic                toggle_q, toggle_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    dir_e                level_dir_q, level_dir_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                step_q, step_d;

    logic [SHIFT_W-1:0]  shift_c;
    logic [PRESC_W-1:0]  tick_mask_c;
    logic                mode_chg_c;
    logic                tick_c;

    // Step-rate exponent clamped so at least one prescaler bit gates the tick.
    always_comb begin
        shift_c = SHIFT_W'(PRESC_W - 1);
        if (32'(speed_i) < PRESC_W - 1) begin
            shift_c = SHIFT_W'(speed_i);
        end
        tick_mask_c = {PRESC_W{1'b1}} >> shift_c;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q      <= MODE_OFF;
            pre_q       <= '0;
            toggle_q    <= 1'b0;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            level_q     <= '0;
            level_dir_q <= DIR_UP;
            pwm_q       <= '0;
            led_q       <= '0;
            step_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            pre_q       <= pre_d;
            toggle_q    <= toggle_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            level_q     <= level_d;
            level_dir_q <= level_dir_d;
            pwm_q       <= pwm_d;
            led_q       <= led_d;
            step_q      <= step_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        pre_d       = pre_q;
        toggle_d    = toggle_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        level_d     = level_q;
        level_dir_d = level_dir_q;
        pwm_d       = pwm_q;
        led_d       = '0;
        tick_c      = 1'b0;
        mode_chg_c  = en_i && (mode_i != mode_q);

        if (en_i) begin
            mode_d = mode_e'(mode_i);
            pre_d  = pre_q + PRESC_W'(1);

            if (mode_chg_c) begin
                // New pattern always starts from a clean state and a full period.
                pre_d       = '0;
                toggle_d    = 1'b0;
                pos_d       = '0;
                dir_d       = DIR_UP;
                level_d     = '0;
                level_dir_d = DIR_UP;
                pwm_d       = '0;
                led_d       = (mode_e'(mode_i) == MODE_SCAN) ? N_LEDS'(1) : '0;
            end else begin
                tick_c = ((pre_q & tick_mask_c) == tick_mask_c);

                case (mode_q)
                    MODE_BLINK: begin
                        led_d = {N_LEDS{toggle_q}};
                        if (tick_c) begin
                            toggle_d = ~toggle_q;
                        end
                    end
                    MODE_SCAN: begin
                        led_d = N_LEDS'(1) << pos_q;
                        if (tick_c) begin
                            // Turn at the ends by stepping inward so no LED dwells twice.
                            if (dir_q == DIR_UP) begin
                                if (pos_q == POS_LAST) begin
                                    dir_d = DIR_DOWN;
                                    pos_d = POS_PENULT;
                                end else begin
                                    pos_d = pos_q + POS_W'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    dir_d = DIR_UP;
                                    pos_d = POS_W'(1);
                                end else begin
                                    pos_d = pos_q - POS_W'(1);
                                end
                            end
                        end
                    end
                    MODE_BREATHE: begin
                        led_d = {N_LEDS{pwm_q < level_q}};
                        pwm_d = pwm_q + PWM_BITS'(1);
                        if (tick_c) begin
                            if (level_dir_q == DIR_UP) begin
                                if (level_q == LEVEL_MAX) begin
                                    level_dir_d = DIR_DOWN;
                                    level_d     = level_q - PWM_BITS'(1);
                                end else begin
                                    level_d = level_q + PWM_BITS'(1);
                                end
                            end else begin
                                if (level_q == '0) begin
                                    level_dir_d = DIR_UP;
                                    level_d     = PWM_BITS'(1);
                                end else begin
                                    level_d = level_q - PWM_BITS'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        led_d = '0;
                    end
                endcase
            end
        end

        step_d = tick_c;
    end

    assign led_o  = led_q;
    assign step_o = step_q;

endmodule
